// File: rtl/io_char_sched.sv
// Character-transfer sequencer: grants one input peripheral at a time and drives its
// 5-bit code onto that device's lines for a slot-aligned hold window, then an all-zero gap.
module io_char_sched #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic        CLOCK,
  input  logic        rst,
  input  logic        IN,
  input  logic        READY,
  input  logic        SLOT,
  input  logic [2:0]  sel_dev,
  input  logic [4:0]  dev_req,
  input  logic [24:0] dev_code,
  output logic [4:0]  dev_ack,
  output logic [4:0]  PUNCHED_TAPE,
  output logic [4:0]  PL6_PHOTO,
  output logic [4:0]  TYPE,
  output logic [4:0]  MAG_IN,
  output logic [4:0]  CARD_INPUT,
  output logic        busy,
  output logic        timeout_err,
  output logic [2:0]  state_dbg,
  output logic [2:0]  rr_ptr_dbg
);

  localparam int MAX_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int MAX_C  = (MAX_HG > TIMEOUT) ? MAX_HG : TIMEOUT;
  localparam int CW     = $clog2(MAX_C) + 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_REQ  = 3'd1,
    WAIT_SLOT = 3'd2,
    DRIVE     = 3'd3,
    GAP       = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic [2:0]      mode_q;
  logic [2:0]      grant_q;
  logic [2:0]      rr_ptr_q;
  logic [4:0]      code_q;
  logic [CW-1:0]   cnt_q;
  logic            timeout_err_q;

  logic            abort;
  logic            sel_ok;
  logic            req_hit;
  logic [2:0]      grant_nxt;
  logic [3:0]      idx;
  logic [4:0]      grant_code;
  logic            hold_last;
  logic            gap_last;
  logic            timer_done;
  logic            ack_fire;

  assign abort      = !IN || READY;
  assign sel_ok     = (sel_dev != 3'd0) && (sel_dev != 3'd6);
  assign hold_last  = (cnt_q == HOLD_LAST);
  assign gap_last   = (cnt_q == GAP_LAST);
  assign timer_done = (cnt_q == TO_LAST);
  // An aborted final DRIVE clock neither acks nor advances the round-robin pointer.
  assign ack_fire   = (state == DRIVE) && !abort && hold_last;

  // Arbitration: fixed device, or first requester at/after rr_ptr wrapping mod 5.
  always_comb begin
    req_hit   = 1'b0;
    grant_nxt = 3'd0;
    idx       = 4'd0;
    if (mode_q == 3'd7) begin
      for (int i = 0; i < 5; i++) begin
        idx = {1'b0, rr_ptr_q} + 4'(i);
        if (idx >= 4'd5) idx = idx - 4'd5;
        if (!req_hit && dev_req[idx[2:0]]) begin
          req_hit   = 1'b1;
          grant_nxt = idx[2:0];
        end
      end
    end else if (mode_q >= 3'd1 && mode_q <= 3'd5) begin
      grant_nxt = mode_q - 3'd1;
      req_hit   = dev_req[mode_q - 3'd1];
    end
  end

  always_comb begin
    case (grant_q)
      3'd0:    grant_code = dev_code[4:0];
      3'd1:    grant_code = dev_code[9:5];
      3'd2:    grant_code = dev_code[14:10];
      3'd3:    grant_code = dev_code[19:15];
      3'd4:    grant_code = dev_code[24:20];
      default: grant_code = 5'd0;
    endcase
  end

  always_ff @(posedge CLOCK or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Abort outranks every other exit from a non-IDLE state.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (IN && !READY && sel_ok) state_nxt = WAIT_REQ;
      WAIT_REQ: begin
        if (abort)           state_nxt = IDLE;
        else if (req_hit)    state_nxt = WAIT_SLOT;
        else if (timer_done) state_nxt = IDLE;
      end
      WAIT_SLOT: begin
        if (abort)     state_nxt = IDLE;
        else if (SLOT) state_nxt = DRIVE;
      end
      DRIVE: begin
        if (abort)          state_nxt = IDLE;
        else if (hold_last) state_nxt = GAP;
      end
      GAP: begin
        if (abort)         state_nxt = IDLE;
        else if (gap_last) state_nxt = WAIT_REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge rst) begin
    if (!rst) begin
      mode_q        <= 3'd0;
      grant_q       <= 3'd0;
      rr_ptr_q      <= 3'd0;
      code_q        <= 5'd0;
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if (state != state_nxt)
        cnt_q <= '0;
      else if (state == WAIT_REQ || state == DRIVE || state == GAP)
        cnt_q <= cnt_q + CW'(1);

      if (state == IDLE && state_nxt == WAIT_REQ) begin
        mode_q        <= sel_dev;
        timeout_err_q <= 1'b0;
      end
      if (state == WAIT_REQ && !abort && !req_hit && timer_done)
        timeout_err_q <= 1'b1;
      if (state == WAIT_REQ && state_nxt == WAIT_SLOT)
        grant_q <= grant_nxt;
      if (state == WAIT_SLOT && state_nxt == DRIVE)
        code_q <= grant_code;
      if (ack_fire && mode_q == 3'd7)
        rr_ptr_q <= (grant_q == 3'd4) ? 3'd0 : grant_q + 3'd1;
    end
  end

  always_comb begin
    PUNCHED_TAPE = 5'd0;
    PL6_PHOTO    = 5'd0;
    TYPE         = 5'd0;
    MAG_IN       = 5'd0;
    CARD_INPUT   = 5'd0;
    dev_ack      = 5'd0;
    busy         = (state != IDLE);
    if (state == DRIVE) begin
      case (grant_q)
        3'd0:    PUNCHED_TAPE = code_q;
        3'd1:    PL6_PHOTO    = code_q;
        3'd2:    TYPE         = code_q;
        3'd3:    MAG_IN       = code_q;
        3'd4:    CARD_INPUT   = code_q;
        default: ;
      endcase
    end
    if (ack_fire) dev_ack = 5'b00001 << grant_q;
  end

  assign timeout_err = timeout_err_q;
  assign state_dbg   = state;
  assign rr_ptr_dbg  = rr_ptr_q;

endmodule
